btn_cond: RTL and testbench

BTN_COND -- requirements
Module: btn_cond

---
 rtl/btn_cond.sv | 169 ++++++++++++++++
 tb/tb_btn_cond.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/btn_cond.sv
// btn_cond: six-button front-end conditioner.
// Each raw button is synchronized and debounced. An arbiter then turns a
// clean single press into a one-cycle command pulse and rejects presses
// that overlap other buttons, reporting them on multi_err.
// Optional feature macro: BTN_AUTOREPEAT_EN. When it is defined, a held
// button re-issues its pulse after REPEAT_DELAY cycles and then every
// REPEAT_PERIOD cycles.
module btn_cond #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic       clk,
  input  logic       _rst,
  input  logic [5:0] raw_btn,
  output logic [5:0] btn_pulse,
  output logic [5:0] btn_level,
  output logic       multi_err
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LOCKOUT
  } state_t;

  // All timing parameters must describe at least one cycle.
  generate
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
      $error("btn_cond: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end
  endgenerate

  logic [5:0]       sync_a;
  logic [5:0]       sync_b;
  logic [CNT_W-1:0] db_cnt [6];
  logic [5:0]       level_prev;
  logic [5:0]       rise;
  logic             rise_onehot;
  state_t           state;

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw_btn;
      sync_b <= sync_a;
    end
  end

  // Per-bit debounce: the stable level flips only after DEBOUNCE_CYCLES
  // consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      btn_level <= '0;
      for (int i = 0; i < 6; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (sync_b[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          db_cnt[i]    <= '0;
          btn_level[i] <= ~btn_level[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Registered rising-edge detect; level_prev stays aligned with rise so the
  // arbiter sees a consistent snapshot of which buttons are down.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      level_prev <= '0;
      rise       <= '0;
    end else begin
      level_prev <= btn_level;
      rise       <= btn_level & ~level_prev;
    end
  end

  assign rise_onehot = (rise != 6'b0) && ((rise & (rise - 6'd1)) == 6'b0);

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_limit;
  logic             repeating;

  // The first repeat waits the long delay, later ones the short period.
  assign rep_limit = repeating ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
`endif

  // Arbiter: accept a lone press, lock out overlapping presses until every
  // button is released, and never react to releases.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state     <= IDLE;
      btn_pulse <= '0;
      multi_err <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt   <= '0;
      repeating <= 1'b0;
`endif
    end else begin
      btn_pulse <= '0;
      multi_err <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt   <= '0;
      repeating <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rise != 6'b0) begin
            if (rise_onehot && (level_prev == rise)) begin
              state     <= PRESSED;
              btn_pulse <= rise;
            end else begin
              state     <= LOCKOUT;
              multi_err <= 1'b1;
            end
          end
        end
        PRESSED: begin
          if (rise != 6'b0) begin
            state     <= LOCKOUT;
            multi_err <= 1'b1;
          end else if (level_prev == 6'b0) begin
            state <= IDLE;
          end else begin
`ifdef BTN_AUTOREPEAT_EN
            // Only the accepted button can be down here, so level_prev is
            // exactly the bit to re-issue.
            if (rep_cnt == rep_limit) begin
              btn_pulse <= level_prev;
              rep_cnt   <= '0;
              repeating <= 1'b1;
            end else begin
              rep_cnt   <= rep_cnt + 1'b1;
              repeating <= repeating;
            end
`else
            state <= PRESSED;
`endif
          end
        end
        LOCKOUT: begin
          if (level_prev == 6'b0) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_cond.sv
// tb_btn_cond: directed bench for btn_cond with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=8, REPEAT_PERIOD=4. Expected pulse/multi_err events are
// queued with their cycle numbers as stimulus is applied and are matched
// against every non-idle output cycle.
module tb_btn_cond;

  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 4;
  localparam int LAT = DB + 4;

  typedef struct {
    int         at;
    logic [5:0] pulse;
    logic       err;
  } event_t;

  logic       clk = 1'b0;
  logic       rst_l;
  logic [5:0] raw_btn;
  logic [5:0] btn_pulse;
  logic [5:0] btn_level;
  logic       multi_err;

  int     cyc = 0;
  int     compared = 0;
  int     mismatched = 0;
  event_t sb[$];

  btn_cond #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    ._rst     (rst_l),
    .raw_btn  (raw_btn),
    .btn_pulse(btn_pulse),
    .btn_level(btn_level),
    .multi_err(multi_err)
  );

  // Free-running clock and a count of rising edges.
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic apply_stimulus(input logic [5:0] value, input int cycles);
    raw_btn = value;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic expect_event(input int at, input logic [5:0] pulse, input logic err);
    event_t ev;
    ev.at    = at;
    ev.pulse = pulse;
    ev.err   = err;
    sb.push_back(ev);
  endtask

  // A lone press pulses once; with auto-repeat it re-pulses on edges
  // strictly before the edge where the arbiter leaves PRESSED.
  task automatic expect_press(input int at, input int leave, input logic [5:0] pulse);
    int e;
    expect_event(at, pulse, 1'b0);
    e = at + RD;
`ifdef BTN_AUTOREPEAT_EN
    while (e < leave) begin
      expect_event(e, pulse, 1'b0);
      e = e + RP;
    end
`else
    if (leave < e) e = leave;
`endif
  endtask

  // Every cycle with a pulse or error must match the next queued event.
  always @(negedge clk) begin : monitor
    event_t ev;
    if (btn_pulse !== 6'b0 || multi_err !== 1'b0) begin
      if (sb.size() == 0) begin
        check_output("unexpected_event", {25'b0, btn_pulse, multi_err}, 32'b0);
      end else begin
        ev = sb.pop_front();
        check_output("event_cycle", cyc, ev.at);
        check_output("event_pulse", btn_pulse, ev.pulse);
        check_output("event_err", multi_err, ev.err);
      end
    end
  end

  initial begin
    int t;
    int r;
    rst_l   = 1'b0;
    raw_btn = 6'b0;
    repeat (3) @(negedge clk);
    check_output("reset_pulse", btn_pulse, 6'b0);
    check_output("reset_level", btn_level, 6'b0);
    check_output("reset_err", multi_err, 1'b0);
    rst_l = 1'b1;
    repeat (5) @(negedge clk);

    // Single press of btn1, held 30 cycles then released.
    t = cyc;
    expect_press(t + LAT, t + 30 + LAT, 6'b100000);
    apply_stimulus(6'b100000, 30);
    check_output("hold_level", btn_level, 6'b100000);
    apply_stimulus(6'b000000, DB + 1);
    check_output("release_level_before", btn_level[5], 1'b1);
    apply_stimulus(6'b000000, 1);
    check_output("release_level_after", btn_level[5], 1'b0);
    apply_stimulus(6'b000000, 10);

    // Short glitches on bit2 must be filtered entirely.
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(6'b000100, 3);
      check_output("glitch_level", btn_level, 6'b0);
      apply_stimulus(6'b000000, 2);
    end
    apply_stimulus(6'b000000, 10);
    check_output("glitch_level_final", btn_level, 6'b0);

    // Bit4 pressed, bit1 added later: lockout, then a clean bit1 press.
    t = cyc;
    expect_press(t + LAT, t + 20 + LAT, 6'b010000);
    apply_stimulus(6'b010000, 20);
    t = cyc;
    expect_event(t + LAT, 6'b0, 1'b1);
    apply_stimulus(6'b010010, 20);
    check_output("overlap_level", btn_level, 6'b010010);
    apply_stimulus(6'b000000, 15);
    t = cyc;
    expect_press(t + LAT, t + 20 + LAT, 6'b000010);
    apply_stimulus(6'b000010, 20);
    apply_stimulus(6'b000000, 15);

    // Bits 0 and 3 together: rejected; a partial release keeps the lockout.
    t = cyc;
    expect_event(t + LAT, 6'b0, 1'b1);
    apply_stimulus(6'b001001, 20);
    check_output("dual_level", btn_level, 6'b001001);
    apply_stimulus(6'b001000, 15);
    check_output("partial_release_level", btn_level, 6'b001000);
    apply_stimulus(6'b000000, 15);
    t = cyc;
    expect_press(t + LAT, t + 20 + LAT, 6'b001000);
    apply_stimulus(6'b001000, 20);
    apply_stimulus(6'b000000, 15);

    // Reset while btn1 is held: outputs clear, then one fresh pulse.
    t = cyc;
    expect_press(t + LAT, t + 11, 6'b100000);
    apply_stimulus(6'b100000, 10);
    rst_l = 1'b0;
    #1;
    check_output("midreset_level", btn_level, 6'b0);
    check_output("midreset_pulse", btn_pulse, 6'b0);
    check_output("midreset_err", multi_err, 1'b0);
    repeat (3) @(negedge clk);
    check_output("midreset_level_held", btn_level, 6'b0);
    r = cyc;
    rst_l = 1'b1;
    expect_press(r + LAT, r + 20 + LAT, 6'b100000);
    apply_stimulus(6'b100000, 20);
    apply_stimulus(6'b000000, 15);

    // Bit0 held 40 cycles: single pulse, or auto-repeat when enabled.
    t = cyc;
    expect_press(t + LAT, t + 40 + LAT, 6'b000001);
    apply_stimulus(6'b000001, 40);
    apply_stimulus(6'b000000, 15);
    check_output("final_level", btn_level, 6'b0);

    check_output("pending_events", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
